// File: rtl/cluster_pkg.sv
// Shared encodings for the cluster layer sequencer: FSM states, stream widths,
// cluster status bit positions and configure word width.
package cluster_pkg;

  localparam int CFG_W = 3;

  localparam int X_W = 12;
  localparam int W_W = 64;
  localparam int B_W = 64;
  localparam int A_W = 4;

  localparam int ST_BUSY  = 0;
  localparam int ST_FAULT = 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_BIAS   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/seq_perf_cnt.sv
// Saturating busy/stall cycle counter pair for cluster_seq.
// Present only when CLUSTER_SEQ_PERF_EN is defined.
`ifdef CLUSTER_SEQ_PERF_EN
module seq_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_a_i,
  input  logic         inc_b_i,
  output logic [W-1:0] cnt_a_o,
  output logic [W-1:0] cnt_b_o
);

  logic [W-1:0] cnt_a_q, cnt_a_d;
  logic [W-1:0] cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (clr_i) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (inc_a_i && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + W'(1);
      if (inc_b_i && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a_o = cnt_a_q;
  assign cnt_b_o = cnt_b_q;

endmodule
`endif

// File: rtl/cluster_seq.sv
// Layer sequencer for one cluster: bias beat, N x/w beat pairs, one activation per neuron.
// Optional perf counters (cyc_cnt/stall_cnt) enabled by CLUSTER_SEQ_PERF_EN.
//
// state  | meaning
// IDLE   | waiting for start; all stream handshakes forced low
// CFG    | configure driven, waiting one cycle of cluster not busy
// BIAS   | forwarding one bias beat
// STREAM | forwarding n_beats x/w beat pairs in lockstep
// DRAIN  | moving one activation downstream
// DONE   | one-cycle done pulse
module cluster_seq
  import cluster_pkg::*;
#(
  parameter int BEAT_W = 6,
  parameter int NOUT_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_mode,
  input  logic [BEAT_W-1:0] n_beats,
  input  logic [NOUT_W-1:0] n_outputs,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [X_W-1:0]    s_x_tdata,
  input  logic              s_x_tvalid,
  output logic              s_x_tready,
  input  logic [W_W-1:0]    s_w_tdata,
  input  logic              s_w_tvalid,
  output logic              s_w_tready,
  input  logic [B_W-1:0]    s_b_tdata,
  input  logic              s_b_tvalid,
  output logic              s_b_tready,
  output logic [X_W-1:0]    m_x_tdata,
  output logic              m_x_tvalid,
  input  logic              m_x_tready,
  output logic [W_W-1:0]    m_w_tdata,
  output logic              m_w_tvalid,
  input  logic              m_w_tready,
  output logic [B_W-1:0]    m_b_tdata,
  output logic              m_b_tvalid,
  input  logic              m_b_tready,
  input  logic [A_W-1:0]    a_tdata,
  input  logic              a_tvalid,
  output logic              a_tready,
  output logic [A_W-1:0]    o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [CFG_W-1:0]  configure,
  input  logic [1:0]        status
`ifdef CLUSTER_SEQ_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [2:0]        state_q, state_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [BEAT_W-1:0] nbeats_q, nbeats_d, beat_cnt_q, beat_cnt_d;
  logic [NOUT_W-1:0] nout_q, nout_d, out_cnt_q, out_cnt_d;
  logic              err_q, err_d;

  logic st_bias, st_stream, st_drain;
  logic xw_ok, b_xfer, xw_xfer, o_xfer, start_acc;

  assign st_bias   = (state_q == S_BIAS);
  assign st_stream = (state_q == S_STREAM);
  assign st_drain  = (state_q == S_DRAIN);

  assign m_x_tdata = s_x_tdata;
  assign m_w_tdata = s_w_tdata;
  assign m_b_tdata = s_b_tdata;
  assign o_tdata   = a_tdata;

  assign m_b_tvalid = st_bias & s_b_tvalid;
  assign s_b_tready = st_bias & m_b_tready;
  assign b_xfer     = st_bias & s_b_tvalid & m_b_tready;

  // x and w only move together so the cluster never sees an x without its w
  assign xw_ok      = s_x_tvalid & s_w_tvalid;
  assign m_x_tvalid = st_stream & xw_ok;
  assign m_w_tvalid = st_stream & xw_ok;
  assign xw_xfer    = st_stream & xw_ok & m_x_tready & m_w_tready;
  assign s_x_tready = xw_xfer;
  assign s_w_tready = xw_xfer;

  assign o_tvalid = st_drain & a_tvalid;
  assign a_tready = st_drain & o_tready;
  assign o_xfer   = st_drain & a_tvalid & o_tready;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign configure = busy ? cfg_q : '0;

  assign start_acc = (state_q == S_IDLE) & start & (n_beats != '0) & (n_outputs != '0);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    nbeats_d   = nbeats_q;
    nout_d     = nout_q;
    beat_cnt_d = beat_cnt_q;
    out_cnt_d  = out_cnt_q;
    err_d      = err_q;
    if ((state_q != S_IDLE) && status[ST_FAULT]) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            cfg_d      = cfg_mode;
            nbeats_d   = n_beats;
            nout_d     = n_outputs;
            beat_cnt_d = '0;
            out_cnt_d  = '0;
            err_d      = 1'b0;
            state_d    = S_CFG;
          end else if (start) begin
            err_d = 1'b1;
          end
        end
        S_CFG: if (!status[ST_BUSY]) state_d = S_BIAS;
        S_BIAS: begin
          if (b_xfer) begin
            beat_cnt_d = '0;
            state_d    = S_STREAM;
          end
        end
        S_STREAM: begin
          if (xw_xfer) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            if (beat_cnt_q == nbeats_q - BEAT_W'(1)) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (o_xfer) begin
            out_cnt_d = out_cnt_q + NOUT_W'(1);
            state_d   = (out_cnt_q == nout_q - NOUT_W'(1)) ? S_DONE : S_BIAS;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      nbeats_q   <= '0;
      nout_q     <= '0;
      beat_cnt_q <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      nbeats_q   <= nbeats_d;
      nout_q     <= nout_d;
      beat_cnt_q <= beat_cnt_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef CLUSTER_SEQ_PERF_EN
  logic stall;
  assign stall = (st_stream & xw_ok & ~xw_xfer) | (st_drain & a_tvalid & ~o_xfer);

  seq_perf_cnt #(.W(32)) u_perf (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .clr_i   (start_acc),
    .inc_a_i (busy),
    .inc_b_i (stall),
    .cnt_a_o (cyc_cnt),
    .cnt_b_o (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_cluster_seq.sv
// Self-checking bench for cluster_seq: table of layer commands plus directed
// corner sequences (zero-length, w toggling, drain stall, fault, mid-layer reset).
module tb_cluster_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_mode = '0;
  logic [5:0]  n_beats = '0;
  logic [7:0]  n_outputs = '0;
  logic        busy, done, err;
  logic [11:0] s_x_tdata = 12'hA5C;
  logic        s_x_tvalid = 1'b1;
  logic        s_x_tready;
  logic [63:0] s_w_tdata = 64'h0123_4567_89AB_CDEF;
  logic        s_w_tvalid;
  logic        s_w_tready;
  logic [63:0] s_b_tdata = 64'hFEDC_BA98_7654_3210;
  logic        s_b_tvalid = 1'b1;
  logic        s_b_tready;
  logic [11:0] m_x_tdata;
  logic        m_x_tvalid;
  logic        m_x_tready = 1'b1;
  logic [63:0] m_w_tdata;
  logic        m_w_tvalid;
  logic        m_w_tready = 1'b1;
  logic [63:0] m_b_tdata;
  logic        m_b_tvalid;
  logic        m_b_tready = 1'b1;
  logic [3:0]  a_tdata = 4'h9;
  logic        a_tvalid = 1'b1;
  logic        a_tready;
  logic [3:0]  o_tdata;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [2:0]  configure;
  logic [1:0]  status = 2'b00;
`ifdef CLUSTER_SEQ_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt;
`endif

  logic w_vld = 1'b1;
  logic w_tog = 1'b0;
  int   cyc_ctr = 0;
  assign s_w_tvalid = w_tog ? cyc_ctr[0] : w_vld;

  cluster_seq dut (
    .CLK(CLK), .RST(RST), .start(start), .cfg_mode(cfg_mode),
    .n_beats(n_beats), .n_outputs(n_outputs),
    .busy(busy), .done(done), .err(err),
    .s_x_tdata(s_x_tdata), .s_x_tvalid(s_x_tvalid), .s_x_tready(s_x_tready),
    .s_w_tdata(s_w_tdata), .s_w_tvalid(s_w_tvalid), .s_w_tready(s_w_tready),
    .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready),
    .m_x_tdata(m_x_tdata), .m_x_tvalid(m_x_tvalid), .m_x_tready(m_x_tready),
    .m_w_tdata(m_w_tdata), .m_w_tvalid(m_w_tvalid), .m_w_tready(m_w_tready),
    .m_b_tdata(m_b_tdata), .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .configure(configure), .status(status)
`ifdef CLUSTER_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1 cyc_ctr = cyc_ctr + 1;
  end

  // Transfer counters, sampled on the falling edge ahead of the edge that completes them
  int n_x, n_w, n_mx, n_b, n_o, n_done, n_busy, n_skew;
  logic [2:0] cfg_seen;

  always @(negedge CLK) begin
    if (s_x_tvalid & s_x_tready) n_x = n_x + 1;
    if (s_w_tvalid & s_w_tready) n_w = n_w + 1;
    if (m_x_tvalid & m_x_tready) n_mx = n_mx + 1;
    if (m_b_tvalid & m_b_tready) n_b = n_b + 1;
    if (o_tvalid & o_tready) n_o = n_o + 1;
    if ((s_x_tvalid & s_x_tready) != (s_w_tvalid & s_w_tready)) n_skew = n_skew + 1;
    if (done) n_done = n_done + 1;
    if (busy) begin
      n_busy = n_busy + 1;
      cfg_seen = configure;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts();
    n_x = 0; n_w = 0; n_mx = 0; n_b = 0; n_o = 0;
    n_done = 0; n_busy = 0; n_skew = 0; cfg_seen = '0;
  endtask

  task automatic pulse_start(input int nb, input int no, input int cfg);
    n_beats = 6'(nb);
    n_outputs = 8'(no);
    cfg_mode = 3'(cfg);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    cmp(name, longint'(busy), 0);
  endtask

  function automatic logic [7:0] hs_vec();
    return {m_x_tvalid, m_w_tvalid, m_b_tvalid, s_x_tready,
            s_w_tready, s_b_tready, a_tready, o_tvalid};
  endfunction

  typedef struct {
    int nb;
    int no;
    int cfg;
    int exp_x;
    int exp_b;
    int exp_o;
    int exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    int k;
    // busy cycles = CFG + n_out*(BIAS + n_beats + DRAIN) + DONE
    vecs[0] = '{nb: 8,  no: 2,   cfg: 5, exp_x: 16,  exp_b: 2,   exp_o: 2,   exp_busy: 22};
    vecs[1] = '{nb: 1,  no: 1,   cfg: 3, exp_x: 1,   exp_b: 1,   exp_o: 1,   exp_busy: 5};
    vecs[2] = '{nb: 3,  no: 4,   cfg: 7, exp_x: 12,  exp_b: 4,   exp_o: 4,   exp_busy: 22};
    vecs[3] = '{nb: 63, no: 1,   cfg: 1, exp_x: 63,  exp_b: 1,   exp_o: 1,   exp_busy: 67};
    vecs[4] = '{nb: 2,  no: 255, cfg: 4, exp_x: 510, exp_b: 255, exp_o: 255, exp_busy: 1022};

    clear_counts();
    #23;
    cmp("rst_busy", longint'(busy), 0);
    cmp("rst_done", longint'(done), 0);
    cmp("rst_err", longint'(err), 0);
    cmp("rst_configure", longint'(configure), 0);
    cmp("rst_handshakes", longint'(hs_vec()), 0);
    step();
    RST = 1'b1;
    step();
    cmp("idle_handshakes", longint'(hs_vec()), 0);
    cmp("pass_x_tdata", longint'(m_x_tdata), 64'hA5C);
    cmp("pass_w_tdata", longint'(m_w_tdata == 64'h0123_4567_89AB_CDEF), 1);
    cmp("pass_b_tdata", longint'(m_b_tdata == 64'hFEDC_BA98_7654_3210), 1);
    cmp("pass_o_tdata", longint'(o_tdata), 9);

    for (int i = 0; i < 5; i++) begin
      clear_counts();
      pulse_start(vecs[i].nb, vecs[i].no, vecs[i].cfg);
      wait_idle($sformatf("v%0d_timeout", i), 3000);
      cmp($sformatf("v%0d_x_beats", i), n_x, vecs[i].exp_x);
      cmp($sformatf("v%0d_w_beats", i), n_w, vecs[i].exp_x);
      cmp($sformatf("v%0d_b_beats", i), n_b, vecs[i].exp_b);
      cmp($sformatf("v%0d_o_beats", i), n_o, vecs[i].exp_o);
      cmp($sformatf("v%0d_done_pulses", i), n_done, 1);
      cmp($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].exp_busy);
      cmp($sformatf("v%0d_configure", i), longint'(cfg_seen), vecs[i].cfg);
      cmp($sformatf("v%0d_err", i), longint'(err), 0);
      cmp($sformatf("v%0d_xw_skew", i), n_skew, 0);
`ifdef CLUSTER_SEQ_PERF_EN
      cmp($sformatf("v%0d_cyc_cnt", i), longint'(cyc_cnt), vecs[i].exp_busy);
      cmp($sformatf("v%0d_stall_cnt", i), longint'(stall_cnt), 0);
`endif
    end

    // zero-length commands
    clear_counts();
    pulse_start(0, 1, 2);
    cmp("zero_beats_err", longint'(err), 1);
    cmp("zero_beats_busy", longint'(busy), 0);
    pulse_start(4, 0, 2);
    cmp("zero_outs_err", longint'(err), 1);
    step();
    cmp("zero_len_no_busy", n_busy, 0);
    pulse_start(1, 1, 2);
    cmp("recover_err_clear", longint'(err), 0);
    cmp("recover_busy", longint'(busy), 1);
    wait_idle("recover_timeout", 100);
    cmp("recover_done", n_done, 1);

    // w valid toggling during STREAM
    clear_counts();
    w_tog = 1'b1;
    pulse_start(8, 1, 6);
    wait_idle("tog_timeout", 200);
    w_tog = 1'b0;
    cmp("tog_x_beats", n_x, 8);
    cmp("tog_w_beats", n_w, 8);
    cmp("tog_mx_beats", n_mx, 8);
    cmp("tog_skew", n_skew, 0);
    cmp("tog_done", n_done, 1);

    // downstream stall in DRAIN
    clear_counts();
    o_tready = 1'b0;
    pulse_start(2, 1, 1);
    k = 0;
    while (!o_tvalid && k < 50) begin step(); k++; end
    cmp("stall_drain_reached", longint'(o_tvalid), 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_tready !== 1'b0 || o_tvalid !== 1'b1 || busy !== 1'b1) bad++;
    end
    cmp("stall_held", bad, 0);
    cmp("stall_no_o_beat", n_o, 0);
    o_tready = 1'b1;
    wait_idle("stall_timeout", 50);
    cmp("stall_o_beats", n_o, 1);
    cmp("stall_done", n_done, 1);

    // cluster fault mid-STREAM
    clear_counts();
    pulse_start(8, 2, 3);
    k = 0;
    while (!m_x_tvalid && k < 50) begin step(); k++; end
    cmp("fault_stream_reached", longint'(m_x_tvalid), 1);
    step(); step(); step();
    status = 2'b10;
    step();
    status = 2'b00;
    cmp("fault_busy", longint'(busy), 0);
    cmp("fault_err", longint'(err), 1);
    cmp("fault_handshakes", longint'(hs_vec()), 0);
    cmp("fault_configure", longint'(configure), 0);
    step();
    cmp("fault_no_done", n_done, 0);
    cmp("fault_stays_idle", longint'(busy), 0);

    // reset during DRAIN of neuron 1 of 3
    clear_counts();
    pulse_start(2, 3, 6);
    k = 0;
    while (n_o < 1 && k < 100) begin step(); k++; end
    o_tready = 1'b0;
    k = 0;
    while (!o_tvalid && k < 50) begin step(); k++; end
    cmp("rst_mid_drain_reached", longint'(o_tvalid && n_o == 1), 1);
    #2 RST = 1'b0;
    #1;
    cmp("rst_mid_busy", longint'(busy), 0);
    cmp("rst_mid_done", longint'(done), 0);
    cmp("rst_mid_err", longint'(err), 0);
    cmp("rst_mid_configure", longint'(configure), 0);
    cmp("rst_mid_handshakes", longint'(hs_vec()), 0);
    step();
    RST = 1'b1;
    o_tready = 1'b1;
    step();
    clear_counts();
    pulse_start(2, 3, 6);
    wait_idle("rerun_timeout", 200);
    cmp("rerun_b_beats", n_b, 3);
    cmp("rerun_x_beats", n_x, 6);
    cmp("rerun_o_beats", n_o, 3);
    cmp("rerun_done", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
